// File: rtl/leaf_hub_core_if.sv
// ---------------------------------------------------------------------------
// leaf_hub_core_if
// Valid/ready message channel used for each of the four leaf hub streams.
//
// Signals:
//   data   WIDTH-bit message, held stable while valid is high
//   valid  producer has a message on data
//   ready  consumer can take the message this cycle
//
// Modports:
//   master  producer side (drives data/valid, samples ready)
//   slave   consumer side (samples data/valid, drives ready)
// ---------------------------------------------------------------------------
interface leaf_hub_core_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/leaf_hub_core.sv
// ---------------------------------------------------------------------------
// leaf_hub_core
// Leaf-side endpoint of the root-hub message network (one per non-root FPGA).
//
// Upstream (TX): messages from the local core get their src field stamped
// with FPGA_ID and are buffered toward the root-hub link.
// Downstream (RX): messages from the root-hub link are filtered on dest;
// those for this FPGA or for BROADCAST_ID are buffered toward the local core,
// everything else is dropped and counted.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   up_rx       slave channel, messages from the root hub
//   up_tx       master channel, messages to the root hub
//   local_rx    slave channel, messages from the local core
//   local_tx    master channel, messages to the local core
//   drop_count  saturating 16-bit count of dropped mis-addressed messages
//
// Header layout: dest = data[CHANNEL_WIDTH-1 -: DEST_WIDTH], src = the
// DEST_WIDTH bits directly below dest.
//
// Optional build macro: LEAF_HUB_LOOPBACK_EN
//   When defined, local messages addressed to FPGA_ID are looped back into
//   the RX FIFO (after src stamping) and share its write port with the
//   upstream path through a 1-bit round-robin arbiter.
// ---------------------------------------------------------------------------
module leaf_hub_core #(
    parameter int                    FPGA_ID       = 1,
    parameter int                    CHANNEL_WIDTH = 64,
    parameter int                    DEST_WIDTH    = 8,
    parameter int                    FIFO_DEPTH    = 4,
    parameter logic [DEST_WIDTH-1:0] BROADCAST_ID  = {DEST_WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    leaf_hub_core_if.slave      up_rx,
    leaf_hub_core_if.master     up_tx,
    leaf_hub_core_if.slave      local_rx,
    leaf_hub_core_if.master     local_tx,
    output logic [15:0]         drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [DEST_WIDTH-1:0] MY_ID = DEST_WIDTH'(FPGA_ID);

    // Readies are held low through reset and come up on the first edge after.
    logic alive;

    logic [CHANNEL_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [CHANNEL_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]            tx_wr;
    logic [PW-1:0]            tx_rd;
    logic [PW-1:0]            rx_wr;
    logic [PW-1:0]            rx_rd;
    logic                     tx_full;
    logic                     tx_empty;
    logic                     rx_full;
    logic                     rx_empty;

    logic                     tx_push;
    logic                     tx_pop;
    logic                     rx_push;
    logic                     rx_pop;
    logic                     up_accept;
    logic                     up_match;
    logic [DEST_WIDTH-1:0]    up_dest;
    logic [CHANNEL_WIDTH-1:0] stamped;
    logic [CHANNEL_WIDTH-1:0] rx_push_data;

    // Full when the wrap bits differ but the index bits match.
    assign tx_empty = (tx_wr == tx_rd);
    assign rx_empty = (rx_wr == rx_rd);
    assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);

    assign up_dest  = up_rx.data[CHANNEL_WIDTH-1 -: DEST_WIDTH];
    assign up_match = (up_dest == MY_ID) || (up_dest == BROADCAST_ID);

    // Local message with its src field replaced by this FPGA's ID.
    assign stamped = {local_rx.data[CHANNEL_WIDTH-1 -: DEST_WIDTH], MY_ID,
                      local_rx.data[CHANNEL_WIDTH-2*DEST_WIDTH-1:0]};

    assign up_accept = up_rx.valid && up_rx.ready;
    assign tx_pop    = !tx_empty && up_tx.ready;
    assign rx_pop    = !rx_empty && local_tx.ready;

`ifdef LEAF_HUB_LOOPBACK_EN
    logic                  rr_ptr;
    logic                  lb_hit;
    logic                  lb_req;
    logic                  contend;
    logic                  lb_accept;
    logic [DEST_WIDTH-1:0] local_dest;

    assign local_dest = local_rx.data[CHANNEL_WIDTH-1 -: DEST_WIDTH];
    assign lb_hit     = (local_dest == MY_ID);
    assign lb_req     = local_rx.valid && lb_hit;
    assign contend    = up_rx.valid && lb_req;

    // rr_ptr = 0 favours upstream, 1 favours loopback; the loser sees ready low.
    assign up_rx.ready    = alive && !rx_full && !(contend && rr_ptr);
    assign local_rx.ready = alive && (lb_hit ? (!rx_full && !(contend && !rr_ptr))
                                             : !tx_full);

    assign lb_accept    = local_rx.valid && local_rx.ready && lb_hit;
    assign tx_push      = local_rx.valid && local_rx.ready && !lb_hit;
    assign rx_push      = (up_accept && up_match) || lb_accept;
    assign rx_push_data = lb_accept ? stamped : up_rx.data;

    // Toggle priority after every grant made while both sources request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (contend && alive && !rx_full) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    assign up_rx.ready    = alive && !rx_full;
    assign local_rx.ready = alive && !tx_full;
    assign tx_push        = local_rx.valid && local_rx.ready;
    assign rx_push        = up_accept && up_match;
    assign rx_push_data   = up_rx.data;
`endif

    // Data outputs are forced to zero while their FIFO is empty so nothing
    // stale is visible after reset.
    assign up_tx.valid    = !tx_empty;
    assign up_tx.data     = tx_empty ? '0 : tx_mem[tx_rd[AW-1:0]];
    assign local_tx.valid = !rx_empty;
    assign local_tx.data  = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];

    // Storage arrays carry no reset; the pointers alone define their contents.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr[AW-1:0]] <= stamped;
        end
        if (rx_push) begin
            rx_mem[rx_wr[AW-1:0]] <= rx_push_data;
        end
    end

    // Pointers, ready enable and the drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive      <= 1'b0;
            tx_wr      <= '0;
            tx_rd      <= '0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            drop_count <= '0;
        end else begin
            alive <= 1'b1;
            if (tx_push) begin
                tx_wr <= tx_wr + PW'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + PW'(1);
            end
            if (rx_push) begin
                rx_wr <= rx_wr + PW'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + PW'(1);
            end
            if (up_accept && !up_match && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/leaf_hub_core.md
Name: leaf_hub_core

Overview:
- Leaf-side endpoint of the root-hub message network; one instance per non-root FPGA.
- Upstream path: accepts 64-bit messages from the local core, stamps the source field and buffers them toward the root-hub link.
- Downstream path: filters and buffers messages from the root-hub link, then hands messages addressed to this FPGA (or broadcast) to the local core.
- Mis-addressed traffic is dropped and counted.

Parameters:
- FPGA_ID, 1, this FPGA's destination ID; 0 is the root, so FPGA_ID must be in 1..NUM_FPGAS-1.
- CHANNEL_WIDTH, 64, message width in bits.
- DEST_WIDTH, 8, width of the dest and src header fields.
- FIFO_DEPTH, 4, entries per direction; must be a power of 2 and at least 2.
- BROADCAST_ID, 8'hFF, dest value accepted by every leaf.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- up_rx_data  input  CHANNEL_WIDTH  message from root hub.
- up_rx_valid  input  1  up_rx_data valid.
- up_rx_ready  output  1  leaf can accept from root.
- up_tx_data  output  CHANNEL_WIDTH  message to root hub.
- up_tx_valid  output  1  up_tx_data valid.
- up_tx_ready  input  1  root accepts.
- local_rx_data  input  CHANNEL_WIDTH  message from local core.
- local_rx_valid  input  1  local_rx_data valid.
- local_rx_ready  output  1  leaf can accept from local core.
- local_tx_data  output  CHANNEL_WIDTH  message to local core.
- local_tx_valid  output  1  local_tx_data valid.
- local_tx_ready  input  1  local core accepts.
- drop_count  output  16  saturating count of dropped mis-addressed messages.

Behaviour:
- Header layout: dest = data[CHANNEL_WIDTH-1 -: DEST_WIDTH]; src = the next DEST_WIDTH bits below dest. All other bits pass through unchanged.
- Handshake: a transfer occurs on a clk edge where valid && ready. Once valid is asserted, data and valid hold until the transfer completes.
- Reset: while reset is high:
  - both FIFOs are empty;
  - up_tx_valid = 0, local_tx_valid = 0;
  - up_rx_ready = 0, local_rx_ready = 0;
  - drop_count = 0;
  - tx/rx data outputs = 0.
- After reset: readies go to 1 on the first clk edge after reset deasserts. Reset asserted mid-operation discards all buffered messages immediately; in-flight handshakes are lost.
- Upstream (TX) path:
  - local_rx_ready = !tx_full.
  - On an accepted transfer, the message is pushed with src overwritten by FPGA_ID.
  - up_tx_valid = !tx_empty; up_tx_data is the FIFO head.
  - Latency: accept at edge N gives up_tx_valid high after edge N (same edge updates the FIFO).
- Downstream (RX) path:
  - up_rx_ready = !rx_full; this ready has no combinational dependence on data.
  - An accepted message with dest == FPGA_ID or dest == BROADCAST_ID is pushed unmodified.
  - Any other accepted message is discarded and drop_count increments, saturating at 16'hFFFF.
  - local_tx_valid = !rx_empty; local_tx_data is the FIFO head; same one-edge latency as the TX path.
- FIFO rules (each direction):
  - Pointers are log2(FIFO_DEPTH)+1 bits; they wrap modulo 2*FIFO_DEPTH. Full when the MSBs differ and the lower bits are equal.
  - Simultaneous push and pop when not full and not empty: occupancy is unchanged.
  - When full: ready = 0 even if a pop occurs in the same cycle (no same-cycle bypass).
  - When empty: no pop is possible; no read-through bypass.
- The two directions are fully independent; no ordering relation exists between them.

Optional Feature:
- Macro: LEAF_HUB_LOOPBACK_EN.
- Enabled:
  - A local_rx message with dest == FPGA_ID is routed into the RX FIFO instead of the TX FIFO, after src stamping.
  - RX FIFO push is arbitrated between upstream and loopback. Round-robin with a 1-bit pointer; reset value favours upstream; the pointer toggles after each grant while both request.
  - The losing source sees ready = 0 that cycle. Because of this, local_rx_ready depends on local_rx_data dest and on the arbitration outcome.
- Disabled:
  - All local_rx messages go upstream regardless of dest.
  - No arbiter; local_rx_ready = !tx_full.

Test Plan:
- Reset then idle: after reset release, the first edge gives up_rx_ready = local_rx_ready = 1, both tx valids = 0, drop_count = 0.
- TX stamping (FPGA_ID = 2): local sends 64'h01AA_0000_1234_5678 with up_tx_ready = 1. Next cycle up_tx_data = 64'h0102_0000_1234_5678; valid drops after one cycle.
- RX filter: root sends dest 2, dest 8'hFF, dest 3. local_tx receives the first two in order; drop_count = 1.
- Backpressure/full (FIFO_DEPTH = 4): local_tx_ready = 0, push 4 matching messages, so up_rx_ready = 0 and a 5th is held. Raise local_tx_ready: 4 messages emerge in order, the 5th is accepted on the first free slot, and nothing is lost.
- Mid-operation reset: 3 messages buffered in each FIFO, pulse reset for one cycle. Both valids = 0, FIFOs empty, drop_count = 0.
- With LEAF_HUB_LOOPBACK_EN: a local message to dest 2 and a root message to dest 2 arrive simultaneously and continuously. Grants alternate (upstream first); up_tx never carries the loopback message.
